// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR addresses, funct3 encodings and RMW op decode
// Contents: CSR_* address localparams, funct3 localparams CSR_RW..CSR_RCI,
//           rmw_op_e enum and decode_op() mapping funct3 to an RMW op.
package csr_pkg;
  localparam logic [11:0] CSR_TOHOST   = 12'h51E;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;
  localparam logic [2:0] CSR_RW  = 3'b001;
  localparam logic [2:0] CSR_RS  = 3'b010;
  localparam logic [2:0] CSR_RC  = 3'b011;
  localparam logic [2:0] CSR_RWI = 3'b101;
  localparam logic [2:0] CSR_RSI = 3'b110;
  localparam logic [2:0] CSR_RCI = 3'b111;
  typedef enum logic [1:0] {OP_NONE, OP_RW, OP_RS, OP_RC} rmw_op_e;
  // funct3[2] only selects the operand source, so the op comes from [1:0]
  function automatic rmw_op_e decode_op(input logic [2:0] f);
    return f[1:0] == 2'b01 ? OP_RW : f[1:0] == 2'b10 ? OP_RS : f[1:0] == 2'b11 ? OP_RC : OP_NONE;
  endfunction
endpackage

// File: rtl/csr_counter.sv
// csr_counter: free-running WIDTH-bit up-counter with increment enable
// Ports: clk, rst (async, active-high), inc (count enable), count (current value).
module csr_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (inc) count <= count + 1'b1;
endmodule

// File: rtl/csr_exec_unit.sv
// csr_exec_unit: Zicsr execute stage with tohost and cycle/instret counters
// Ports: clk, rst (async, active-high); csr_valid/stall/csr_addr/csr_func/
//        csr_rs1_data/csr_zimm describe the CSR instruction; inst_retire bumps
//        instret; csr_rdata/csr_rvalid/csr_illegal are the registered result;
//        tohost exposes the tohost register.
module csr_exec_unit
  import csr_pkg::*;
#(
  parameter int              DWIDTH      = 32,
  parameter int              CNT_WIDTH   = 64,
  parameter logic [11:0]     TOHOST_ADDR = CSR_TOHOST,
  parameter logic [DWIDTH-1:0] TOHOST_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csr_valid,
  input  logic              stall,
  input  logic [11:0]       csr_addr,
  input  logic [2:0]        csr_func,
  input  logic [DWIDTH-1:0] csr_rs1_data,
  input  logic [4:0]        csr_zimm,
  input  logic              inst_retire,
  output logic [DWIDTH-1:0] csr_rdata,
  output logic              csr_rvalid,
  output logic              csr_illegal,
  output logic [DWIDTH-1:0] tohost
);
  logic [CNT_WIDTH-1:0] cycle, instret;
  logic                 accept, is_th, is_ro, wr, bad;
  rmw_op_e              op;
  logic [DWIDTH-1:0]    src, old, new_val;

  csr_counter #(.WIDTH(CNT_WIDTH)) u_cycle (.clk(clk), .rst(rst), .inc(1'b1), .count(cycle));
  csr_counter #(.WIDTH(CNT_WIDTH)) u_instret (.clk(clk), .rst(rst), .inc(inst_retire), .count(instret));

  assign accept = csr_valid & ~stall;

  always_comb begin
    op      = decode_op(csr_func);
    src     = csr_func[2] ? {{(DWIDTH-5){1'b0}}, csr_zimm} : csr_rs1_data;
    is_th   = csr_addr == TOHOST_ADDR;
    is_ro   = csr_addr inside {CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH};
    old     = is_th                      ? tohost :
              csr_addr == CSR_CYCLE      ? cycle[DWIDTH-1:0] :
              csr_addr == CSR_CYCLEH     ? cycle[CNT_WIDTH-1:DWIDTH] :
              csr_addr == CSR_INSTRET    ? instret[DWIDTH-1:0] :
              csr_addr == CSR_INSTRETH   ? instret[CNT_WIDTH-1:DWIDTH] : '0;
    // set/clear with a zero rs1/zimm field is a pure read and never writes
    wr      = op == OP_RW || (op != OP_NONE && csr_zimm != 5'd0);
    bad     = op == OP_NONE || !(is_th || is_ro) || (is_ro && wr);
    new_val = op == OP_RW ? src : op == OP_RS ? (old | src) : (old & ~src);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) tohost <= TOHOST_RST;
    else if (accept && !bad && is_th && wr) tohost <= new_val;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      csr_rdata   <= '0;
      csr_rvalid  <= 1'b0;
      csr_illegal <= 1'b0;
    end else begin
      csr_rvalid  <= accept;
      csr_illegal <= accept & bad;
      if (accept) csr_rdata <= bad ? '0 : old;
    end
endmodule

// File: tb/tb_csr_exec_unit.sv
// tb_csr_exec_unit: scoreboard bench for csr_exec_unit against a behavioural CSR model
module tb_csr_exec_unit;
  import csr_pkg::*;
  logic        clk = 0, rst = 1, csr_valid = 0, stall = 0, inst_retire = 0;
  logic [11:0] csr_addr = 0;
  logic [2:0]  csr_func = 0;
  logic [31:0] csr_rs1_data = 0;
  logic [4:0]  csr_zimm = 0;
  logic [31:0] csr_rdata, tohost;
  logic        csr_rvalid, csr_illegal;

  csr_exec_unit dut (
    .clk(clk), .rst(rst), .csr_valid(csr_valid), .stall(stall), .csr_addr(csr_addr),
    .csr_func(csr_func), .csr_rs1_data(csr_rs1_data), .csr_zimm(csr_zimm),
    .inst_retire(inst_retire), .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid),
    .csr_illegal(csr_illegal), .tohost(tohost)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        ill;
    logic [31:0] th;
  } exp_t;
  exp_t q[$];

  longint unsigned m_cycle = 0, m_instret = 0;
  logic [31:0]     m_tohost = 0;
  int              n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: architectural CSR file evaluated on every accept edge
  always @(posedge clk) begin
    if (!rst) begin
      if (csr_valid && !stall) begin
        exp_t        e;
        logic [31:0] s, o;
        logic        legal_f, mapped, ro, writes;
        legal_f = csr_func inside {CSR_RW, CSR_RS, CSR_RC, CSR_RWI, CSR_RSI, CSR_RCI};
        s       = csr_func[2] ? 32'(csr_zimm) : csr_rs1_data;
        mapped  = 1;
        ro      = 1;
        case (csr_addr)
          CSR_TOHOST:   begin o = m_tohost; ro = 0; end
          CSR_CYCLE:    o = m_cycle[31:0];
          CSR_CYCLEH:   o = m_cycle[63:32];
          CSR_INSTRET:  o = m_instret[31:0];
          CSR_INSTRETH: o = m_instret[63:32];
          default:      begin o = 0; mapped = 0; end
        endcase
        writes = csr_func == CSR_RW || csr_func == CSR_RWI || csr_zimm != 0;
        e.ill  = !legal_f || !mapped || (ro && writes);
        e.rd   = e.ill ? 32'h0 : o;
        if (!e.ill && !ro && writes)
          case (csr_func)
            CSR_RW, CSR_RWI: m_tohost = s;
            CSR_RS, CSR_RSI: m_tohost = o | s;
            default:         m_tohost = o & ~s;
          endcase
        e.th = m_tohost;
        q.push_back(e);
      end
      m_cycle++;
      if (inst_retire) m_instret++;
    end
  end

  // Monitor: every registered result must match the oldest outstanding expectation
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (csr_rvalid) begin
        if (q.size() == 0) chk("unexpected_rvalid", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("rdata", csr_rdata, e.rd);
          chk("illegal", csr_illegal, e.ill);
          chk("tohost", tohost, e.th);
        end
      end else begin
        if (q.size() != 0) begin
          chk("missing_rvalid", 0, 1);
          q.delete();
        end
        chk("idle_illegal", csr_illegal, 0);
      end
    end
  end

  task automatic drive(input logic [11:0] a, input logic [2:0] f, input logic [31:0] d,
                       input logic [4:0] z, input logic st, input logic ret);
    @(negedge clk);
    csr_valid = 1; csr_addr = a; csr_func = f; csr_rs1_data = d; csr_zimm = z;
    stall = st; inst_retire = ret;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      csr_valid = 0; stall = 0; inst_retire = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    chk("rst_rvalid", csr_rvalid, 0);
    chk("rst_illegal", csr_illegal, 0);
    chk("rst_rdata", csr_rdata, 0);
    chk("rst_tohost", tohost, 0);
    rst = 0;
    idle(10);
    drive(CSR_CYCLE, CSR_RS, 0, 0, 0, 0);
    idle(2);
    drive(CSR_TOHOST, CSR_RW, 32'hDEADBEEF, 5'd1, 0, 0);
    drive(CSR_TOHOST, CSR_RSI, 0, 5'h10, 0, 0);
    drive(CSR_TOHOST, CSR_RC, 32'hFFFF0000, 5'd2, 0, 0);
    idle(2);
    chk("tohost_rmw", tohost, 32'h0000BEFF);
    force dut.u_instret.count = 64'hFFFF_FFFF_FFFF_FFFF;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.u_instret.count;
    inst_retire = 1;
    idle(1);
    drive(CSR_INSTRET, CSR_RS, 0, 0, 0, 0);
    drive(CSR_INSTRETH, CSR_RCI, 0, 0, 0, 0);
    drive(CSR_CYCLE, CSR_RW, 32'h1234, 5'd3, 0, 0);
    drive(CSR_CYCLE, CSR_RS, 0, 0, 0, 0);
    drive(12'h123, CSR_RS, 0, 0, 0, 0);
    drive(CSR_TOHOST, 3'b000, 1, 1, 0, 0);
    drive(CSR_TOHOST, 3'b100, 1, 1, 0, 0);
    idle(2);
    repeat (3) drive(CSR_TOHOST, CSR_RW, 5, 5'd1, 1, 0);
    chk("stall_tohost", tohost, 32'h0000BEFF);
    chk("stall_rvalid", csr_rvalid, 0);
    drive(CSR_TOHOST, CSR_RW, 5, 5'd1, 0, 0);
    idle(1);
    chk("release_tohost", tohost, 5);
    repeat (400) begin
      logic [11:0] a;
      case ($urandom_range(0, 5))
        0: a = CSR_CYCLE;
        1: a = CSR_CYCLEH;
        2: a = CSR_INSTRET;
        3: a = CSR_INSTRETH;
        4: a = CSR_TOHOST;
        default: a = 12'($urandom);
      endcase
      @(negedge clk);
      csr_valid    = $urandom_range(0, 3) != 0;
      stall        = $urandom_range(0, 4) == 0;
      inst_retire  = $urandom_range(0, 1) == 1;
      csr_addr     = a;
      csr_func     = 3'($urandom);
      csr_rs1_data = $urandom;
      csr_zimm     = $urandom_range(0, 2) == 0 ? 5'd0 : 5'($urandom);
    end
    drive(CSR_TOHOST, CSR_RW, 32'hA5A5A5A5, 5'd1, 0, 0);
    idle(1);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("async_rvalid", csr_rvalid, 0);
    chk("async_tohost", tohost, 0);
    chk("async_rdata", csr_rdata, 0);
    q.delete();
    m_cycle = 0; m_instret = 0; m_tohost = 0;
    @(negedge clk);
    rst = 0;
    idle(3);
    drive(CSR_CYCLE, CSR_RS, 0, 0, 0, 0);
    drive(CSR_TOHOST, CSR_RS, 0, 0, 0, 0);
    idle(3);
    chk("drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
